// File: rtl/uncached_dbus_bridge.sv
// ----------------------------------------------------------------------------
// uncached_dbus_bridge
//
// Responder end of the datapath's uncached data-bus port. Takes one dbus
// request at a time and turns it into a single-beat AXI3 read or write. The
// completion comes back on the dbus response. The datapath must keep req
// low until data_ok is seen, so only one request is ever in flight.
//
// Optional feature macro: UNCACHED_WBUF_EN
//   defined   - one-entry posted write buffer. A write's data_ok pulses the
//               cycle after accept and the AXI write finishes in the
//               background. addr_ok stays low until its B handshake.
//   undefined - a write's data_ok is raised only after the B handshake.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   req_i               dbus request {valid, is_write, size, addr, data, strobe}
//   resp_o              dbus response {addr_ok, data_ok, data}
//   araddr_o/arsize_o   AR channel payload, arvalid_o / arready_i handshake
//   rdata_i             R channel data, rvalid_i / rready_o handshake
//   awaddr_o/awsize_o   AW channel payload, awvalid_o / awready_i handshake
//   wdata_o/wstrb_o     W channel payload, wvalid_o / wready_i handshake
//   bvalid_i/bready_o   B channel handshake (bresp is ignored)
// ----------------------------------------------------------------------------
package uncached_dbus_pkg;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strobe;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;
endpackage

module uncached_dbus_bridge
  import uncached_dbus_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  dbus_req_t         req_i,
  output dbus_resp_t        resp_o,
  output logic [ADDR_W-1:0] araddr_o,
  output logic [2:0]        arsize_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  input  logic [31:0]       rdata_i,
  input  logic              rvalid_i,
  output logic              rready_o,
  output logic [ADDR_W-1:0] awaddr_o,
  output logic [2:0]        awsize_o,
  output logic              awvalid_o,
  input  logic              awready_i,
  output logic [31:0]       wdata_o,
  output logic [3:0]        wstrb_o,
  output logic              wvalid_o,
  input  logic              wready_i,
  input  logic              bvalid_i,
  output logic              bready_o
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B, DONE} state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_q;
  logic [3:0]  strobe_q;
  logic [31:0] rspData_q;
  logic        dataOk_q;
  logic        arvalid_q;
  logic        rready_q;
  logic        awvalid_q;
  logic        wvalid_q;
  logic        bready_q;
  logic        awDone;
  logic        wDone;

  // A write channel counts as done once its valid has dropped, or in the
  // cycle its handshake happens. So AW and W may finish in either order, and
  // the FSM moves on to B in the cycle the later of the two completes.
  assign awDone = ~awvalid_q | awready_i;
  assign wDone  = ~wvalid_q  | wready_i;

  // addr_ok is the only combinational output. It is offered only in IDLE.
  // It is also held low during reset, so that every output reads 0 then.
  assign resp_o.addr_ok = (state_q == IDLE) & req_i.valid & ~reset;
  assign resp_o.data_ok = dataOk_q;
  assign resp_o.data    = rspData_q;

  // AXI payloads come straight from the request latched at accept. Reads and
  // writes share one address/size latch because only one is ever in flight.
  assign araddr_o  = ADDR_W'(addr_q);
  assign awaddr_o  = ADDR_W'(addr_q);
  assign arsize_o  = {1'b0, size_q};
  assign awsize_o  = {1'b0, size_q};
  assign wdata_o   = wdata_q;
  assign wstrb_o   = strobe_q;
  assign arvalid_o = arvalid_q;
  assign rready_o  = rready_q;
  assign awvalid_o = awvalid_q;
  assign wvalid_o  = wvalid_q;
  assign bready_o  = bready_q;

  // Main transaction FSM. All handshake outputs are registered and change
  // together with the state. data_ok and the response data are one-cycle
  // pulses: they default back to 0 every cycle, and the FSM sets them only
  // in the cycle before they are meant to appear. The read or write
  // direction is held in the state itself, so is_write needs no register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      strobe_q  <= '0;
      rspData_q <= '0;
      dataOk_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      dataOk_q  <= 1'b0;
      rspData_q <= '0;
      case (state_q)
        IDLE: begin
          if (req_i.valid) begin
            addr_q   <= req_i.addr;
            size_q   <= req_i.size;
            wdata_q  <= req_i.data;
            strobe_q <= req_i.strobe;
            if (req_i.is_write) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR_AW;
`ifdef UNCACHED_WBUF_EN
              dataOk_q  <= 1'b1;
`endif
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= RD_A;
            end
          end
        end
        RD_A: begin
          if (arready_i) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_D;
          end
        end
        RD_D: begin
          if (rvalid_i) begin
            rready_q  <= 1'b0;
            rspData_q <= rdata_i;
            dataOk_q  <= 1'b1;
            state_q   <= DONE;
          end
        end
        WR_AW: begin
          if (awvalid_q && awready_i) begin
            awvalid_q <= 1'b0;
          end
          if (wvalid_q && wready_i) begin
            wvalid_q <= 1'b0;
          end
          if (awDone && wDone) begin
            bready_q <= 1'b1;
            state_q  <= WR_B;
          end
        end
        WR_B: begin
          if (bvalid_i) begin
            bready_q <= 1'b0;
`ifdef UNCACHED_WBUF_EN
            state_q  <= IDLE;
`else
            dataOk_q <= 1'b1;
            state_q  <= DONE;
`endif
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uncached_dbus_bridge.sv
// ----------------------------------------------------------------------------
// tb_uncached_dbus_bridge
//
// Bench for uncached_dbus_bridge. A small AXI responder returns each ready or
// valid a configurable number of cycles after the matching request signal
// appears. Each accepted dbus request pushes its expected response data and
// its expected data_ok cycle onto a scoreboard queue. A monitor pops the
// queue and compares whenever data_ok is seen. Directed sections also check
// channel signals cycle by cycle.
// ----------------------------------------------------------------------------
module tb_uncached_dbus_bridge;
  import uncached_dbus_pkg::*;

`ifdef UNCACHED_WBUF_EN
  localparam bit WBUF = 1'b1;
`else
  localparam bit WBUF = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    int          cycle;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  dbus_req_t   req = '0;
  dbus_resp_t  resp;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready = 1'b0;
  logic        bvalid = 1'b0;
  logic        bready;

  int          checkCount = 0;
  int          failCount = 0;
  int          cycleCount = 0;
  int          lastDataOkCycle = -1;
  exp_t        expQ[$];

  int          arDelay = 0;
  int          rDelay = 0;
  int          awDelay = 0;
  int          wDelay = 0;
  int          bDelay = 0;
  logic [31:0] slaveRdata = '0;
  int          arCnt = 0;
  int          rCnt = 0;
  int          awCnt = 0;
  int          wCnt = 0;
  int          bCnt = 0;

  uncached_dbus_bridge #(.ADDR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req),
    .resp_o    (resp),
    .araddr_o  (araddr),
    .arsize_o  (arsize),
    .arvalid_o (arvalid),
    .arready_i (arready),
    .rdata_i   (rdata),
    .rvalid_i  (rvalid),
    .rready_o  (rready),
    .awaddr_o  (awaddr),
    .awsize_o  (awsize),
    .awvalid_o (awvalid),
    .awready_i (awready),
    .wdata_o   (wdata),
    .wstrb_o   (wstrb),
    .wvalid_o  (wvalid),
    .wready_i  (wready),
    .bvalid_i  (bvalid),
    .bready_o  (bready)
  );

  // 10 ns clock. The cycle number advances at every rising edge.
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  // Counts one comparison and reports it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // AXI responder. Each ready or valid rises once its partner signal has
  // been high for more than the configured delay, counted in cycles.
  always @(negedge clk) begin
    arCnt   = arvalid ? arCnt + 1 : 0;
    arready = arvalid && (arCnt > arDelay);
    rCnt    = rready ? rCnt + 1 : 0;
    rvalid  = rready && (rCnt > rDelay);
    rdata   = rvalid ? slaveRdata : 32'h0;
    awCnt   = awvalid ? awCnt + 1 : 0;
    awready = awvalid && (awCnt > awDelay);
    wCnt    = wvalid ? wCnt + 1 : 0;
    wready  = wvalid && (wCnt > wDelay);
    bCnt    = bready ? bCnt + 1 : 0;
    bvalid  = bready && (bCnt > bDelay);
  end

  // Scoreboard monitor. Every data_ok must match the oldest expected entry,
  // both in its data and in the cycle it arrives.
  always @(negedge clk) begin
    if (resp.data_ok === 1'b1) begin
      lastDataOkCycle = cycleCount;
      if (expQ.size() == 0) begin
        checkOutput("spurious data_ok", 32'h1, 32'h0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("resp data", resp.data, e.data);
        checkOutput("data_ok cycle", cycleCount, e.cycle);
      end
    end
  end

  // Watchdog in case something hangs that no bounded wait catches.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic setDelays(input int ar, input int r, input int aw, input int w, input int b);
    arDelay = ar;
    rDelay  = r;
    awDelay = aw;
    wDelay  = w;
    bDelay  = b;
  endtask

  // Raises a request, waits (bounded) for addr_ok, and records what the
  // response should be. Returns one cycle after accept, with valid dropped.
  task automatic applyStimulus(input bit isWr, input logic [1:0] sz,
                               input logic [31:0] ad, input logic [31:0] dt,
                               input logic [3:0] st, output int acceptCycle);
    int   waitCnt;
    int   lat;
    exp_t e;
    waitCnt        = 0;
    acceptCycle    = -1;
    req.valid      = 1'b1;
    req.is_write   = isWr;
    req.size       = sz;
    req.addr       = ad;
    req.data       = dt;
    req.strobe     = st;
    #1;
    while (resp.addr_ok !== 1'b1 && waitCnt < 60) begin
      tick();
      waitCnt++;
    end
    if (resp.addr_ok !== 1'b1) begin
      checkOutput("accept timeout", {31'b0, resp.addr_ok}, 32'h1);
    end else begin
      acceptCycle = cycleCount;
      if (isWr) begin
        lat = WBUF ? 1 : 3 + ((awDelay > wDelay) ? awDelay : wDelay) + bDelay;
      end else begin
        lat = 3 + arDelay + rDelay;
      end
      e.data  = isWr ? 32'h0 : slaveRdata;
      e.cycle = acceptCycle + lat;
      expQ.push_back(e);
    end
    tick();
    req.valid = 1'b0;
  endtask

  task automatic waitIdle(input int limit);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    if (expQ.size() != 0) begin
      checkOutput("drain timeout", expQ.size(), 32'h0);
      expQ.delete();
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " ctrl"}, {25'b0, resp.addr_ok, resp.data_ok, arvalid, rready,
                                 awvalid, wvalid, bready}, 32'h0);
    checkOutput({tag, " resp data"}, resp.data, 32'h0);
    checkOutput({tag, " araddr"}, araddr, 32'h0);
    checkOutput({tag, " awaddr"}, awaddr, 32'h0);
    checkOutput({tag, " wdata"}, wdata, 32'h0);
    checkOutput({tag, " strb/size"}, {22'b0, wstrb, arsize, awsize}, 32'h0);
  endtask

  initial begin
    int acc;
    int acc2;

    repeat (3) tick();
    checkAllZero("in reset");
    reset = 1'b0;
    tick();
    checkAllZero("idle");

    // Read where arready comes 3 cycles late. data_ok is due at cycle 6.
    $display("[TB] read with delayed arready");
    setDelays(3, 0, 0, 0, 0);
    slaveRdata = 32'hDEAD_BEEF;
    applyStimulus(1'b0, 2'd2, 32'h1FD0_F000, 32'h0, 4'h0, acc);
    checkOutput("t1 araddr", araddr, 32'h1FD0_F000);
    checkOutput("t1 arsize", {29'b0, arsize}, 32'h2);
    for (int c = 1; c <= 5; c++) begin
      checkOutput($sformatf("t1 arvalid @%0d", c), {31'b0, arvalid}, {31'b0, c <= 4});
      checkOutput($sformatf("t1 rready @%0d", c), {31'b0, rready}, {31'b0, c == 5});
      tick();
    end
    waitIdle(20);

    // Byte write with all readies prompt.
    $display("[TB] byte write");
    setDelays(0, 0, 0, 0, 0);
    applyStimulus(1'b1, 2'd0, 32'h1FD0_0001, 32'h0000_AB00, 4'b0010, acc);
    checkOutput("t2 awaddr", awaddr, 32'h1FD0_0001);
    checkOutput("t2 awsize", {29'b0, awsize}, 32'h0);
    checkOutput("t2 wstrb", {28'b0, wstrb}, 32'h2);
    checkOutput("t2 wdata", wdata, 32'h0000_AB00);
    checkOutput("t2 aw/w valid", {30'b0, awvalid, wvalid}, 32'h3);
    waitIdle(20);

    // Write where AW completes at cycle 1 but W only at cycle 4.
    $display("[TB] write with late wready");
    setDelays(0, 0, 0, 3, 0);
    applyStimulus(1'b1, 2'd2, 32'h1FD0_0010, 32'h1234_5678, 4'hF, acc);
    for (int c = 1; c <= 5; c++) begin
      checkOutput($sformatf("t3 awvalid @%0d", c), {31'b0, awvalid}, {31'b0, c == 1});
      checkOutput($sformatf("t3 wvalid @%0d", c), {31'b0, wvalid}, {31'b0, c <= 4});
      checkOutput($sformatf("t3 bready @%0d", c), {31'b0, bready}, {31'b0, c == 5});
      tick();
    end
    waitIdle(20);

    // Back-to-back read then write with valid held between them.
    $display("[TB] back-to-back read then write");
    setDelays(0, 0, 0, 0, 0);
    slaveRdata = 32'hCAFE_0001;
    applyStimulus(1'b0, 2'd2, 32'h1FD0_0020, 32'h0, 4'h0, acc);
    applyStimulus(1'b1, 2'd2, 32'h1FD0_0024, 32'h5555_AAAA, 4'hF, acc2);
    checkOutput("t4 accept after data_ok", acc2, lastDataOkCycle + 1);
    checkOutput("t4 accept gap", acc2 - acc, 32'd4);
    waitIdle(20);

    // Reset while waiting in RD_D, then a normal read.
    $display("[TB] reset mid-read");
    setDelays(0, 5, 0, 0, 0);
    slaveRdata = 32'h0BAD_0BAD;
    applyStimulus(1'b0, 2'd2, 32'h1FD0_0030, 32'h0, 4'h0, acc);
    tick();
    checkOutput("t5 rready before reset", {31'b0, rready}, 32'h1);
    reset = 1'b1;
    expQ.delete();
    tick();
    checkAllZero("t5 after reset");
    reset = 1'b0;
    setDelays(0, 0, 0, 0, 0);
    slaveRdata = 32'h1357_9BDF;
    applyStimulus(1'b0, 2'd2, 32'h1FD0_0034, 32'h0, 4'h0, acc);
    waitIdle(20);

    // Write then read with valid held. With the posted write buffer the read
    // is accepted the cycle after bvalid. Without it, the cycle after DONE.
    $display("[TB] write then read");
    slaveRdata = 32'h2468_ACE0;
    applyStimulus(1'b1, 2'd2, 32'h1FD0_0040, 32'hFEED_F00D, 4'hF, acc);
    applyStimulus(1'b0, 2'd2, 32'h1FD0_0044, 32'h0, 4'h0, acc2);
    checkOutput("t6 read accept gap", acc2 - acc, WBUF ? 32'd3 : 32'd4);
    waitIdle(20);

    // Mixed transactions with random delays and data.
    $display("[TB] random mix");
    for (int i = 0; i < 8; i++) begin
      bit          isWr;
      logic [31:0] ad;
      logic [31:0] dt;
      isWr = 1'($urandom_range(0, 1));
      ad   = {$urandom} & 32'h1FFF_FFFC;
      dt   = $urandom;
      setDelays($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                $urandom_range(0, 2), $urandom_range(0, 2));
      slaveRdata = $urandom;
      applyStimulus(isWr, 2'd2, ad, dt, 4'hF, acc);
      waitIdle(40);
    end
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
